// File: rtl/riscv_fetch_stage_if.sv
// Bundled fetch-stage handshakes: instruction-memory request/response,
// EX redirect and the IF/ID valid/ready hand-off.
// master = fetch stage view, slave = memory/pipeline environment view.
interface riscv_fetch_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_id_valid;
    logic            if_id_ready;
    logic [XLEN-1:0] if_id_pc;
    logic [31:0]     if_id_instr;
    logic [XLEN-1:0] if_id_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus4,
        input  if_id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus4,
        output if_id_ready
    );
endinterface

// File: rtl/riscv_fetch_stage.sv
// IF stage of a 5-stage RISC-V pipeline: owns the PC, issues word fetches to a
// 1-cycle-latency instruction memory, buffers returned words in a prefetch
// queue and hands them to ID over valid/ready. EX redirects flush the queue
// and bump an epoch so any stale response is discarded.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_stall.
module riscv_fetch_stage #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     QUEUE_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall,
`endif
    riscv_fetch_stage_if.master bus
);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {S_RESET, S_RUN} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_epoch;
    logic            r_inflight;
    logic            r_tag_epoch;
    logic [XLEN-1:0] r_tag_pc;

    logic [XLEN-1:0]  r_q_pc    [QUEUE_DEPTH];
    logic [31:0]      r_q_instr [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic            w_credit_ok;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_head_pc;

    // Queued words plus the one possibly in flight never exceed the queue size,
    // so a returning response always has a slot.
    assign w_credit_ok   = (r_count + CNT_W'(r_inflight)) < CNT_W'(QUEUE_DEPTH);
    assign w_req_valid   = (r_state == S_RUN) && w_credit_ok && !bus.redirect_valid;
    assign w_req_fire    = w_req_valid && bus.imem_req_ready;
    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == CNT_W'(QUEUE_DEPTH));
    // A redirect discards both a same-cycle pop and a same-cycle response.
    assign w_pop         = !w_empty && bus.if_id_ready && !bus.redirect_valid;
    assign w_push        = bus.imem_rsp_valid && r_inflight && (r_tag_epoch == r_epoch)
                           && !bus.redirect_valid;
    assign w_redirect_pc = bus.redirect_pc & ~XLEN'(3);
    assign w_head_pc     = r_q_pc[r_rptr];

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    // Outputs read as zero while nothing is presented, including during reset.
    assign bus.if_id_valid    = !w_empty;
    assign bus.if_id_pc       = w_empty ? '0 : w_head_pc;
    assign bus.if_id_instr    = w_empty ? '0 : r_q_instr[r_rptr];
    assign bus.if_id_pc_plus4 = w_empty ? '0 : w_head_pc + XLEN'(4);

    // Control FSM, fetch PC, epoch and the tag of the request in flight.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RESET;
            r_fetch_pc  <= RESET_PC & ~XLEN'(3);
            r_epoch     <= 1'b0;
            r_inflight  <= 1'b0;
            r_tag_epoch <= 1'b0;
            r_tag_pc    <= '0;
        end else begin
            r_state    <= S_RUN;
            r_inflight <= w_req_fire;
            if (w_req_fire) begin
                r_tag_pc    <= r_fetch_pc;
                r_tag_epoch <= r_epoch;
            end
            if (bus.redirect_valid) begin
                r_epoch    <= ~r_epoch;
                r_fetch_pc <= w_redirect_pc;
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
        end
    end

    // Prefetch queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk) begin
        if (rst || bus.redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Prefetch queue storage.
    // NOTE: storage is deliberately not reset; occupancy is reset and the
    // outputs are gated by it, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wptr]    <= r_tag_pc;
            r_q_instr[r_wptr] <= bus.imem_rsp_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && w_full));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    // Delivered-instruction and ID-stall counters; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_pop)                      r_perf_fetched <= r_perf_fetched + 32'd1;
            if (!w_empty && !bus.if_id_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif
endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Self-checking bench for riscv_fetch_stage. Directed scenarios push the
// expected IF/ID stream into a scoreboard queue; a monitor pops and compares
// whenever ID accepts a word. Inputs change on the falling edge, outputs are
// sampled a few time units after it.
`timescale 1ns/1ps
module tb_riscv_fetch_stage;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   fire_count = 0;
    logic pend_v = 1'b0;
    logic [31:0] pend_addr = '0;
    exp_t exp_q[$];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    riscv_fetch_stage_if #(.XLEN(32)) bus ();

    riscv_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .QUEUE_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic [31:0] pc4);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        e.pc4   = pc4;
        exp_q.push_back(e);
    endtask

    // Instruction memory: answers every accepted request one cycle later.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            bus.imem_rsp_valid = pend_v;
            bus.imem_rsp_data  = pend_v ? mem_word(pend_addr) : 32'h0;
            #1;
            pend_v    = bus.imem_req_valid && bus.imem_req_ready;
            pend_addr = bus.imem_req_addr;
            if (pend_v) fire_count++;
        end
    end

    // Monitor: every word ID accepts is compared against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !bus.redirect_valid && bus.if_id_valid && bus.if_id_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_instr: got pc %h, required no delivery", bus.if_id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_id_pc", bus.if_id_pc, e.pc);
                    check("if_id_instr", bus.if_id_instr, e.instr);
                    check("if_id_pc_plus4", bus.if_id_pc_plus4, e.pc4);
                end
            end
        end
    end

    // Leaves the bench at the falling edge of the single RESET-state cycle.
    task automatic do_reset();
        @(negedge clk);
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_id_ready    = 1'b0;
        bus.imem_req_ready = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        fire_count = 0;
    endtask

    // Lets ID consume until the scoreboard is empty, then stalls ID.
    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.if_id_ready = 1'b0;
        check(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_id_ready    = 1'b0;

        // 1: reset state, then a straight-line stream 0x0..0x1C
        do_reset();
        bus.if_id_ready = 1'b1;
        #3;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_if_id_valid", 32'(bus.if_id_valid), 32'd0);
        check("rst_if_id_pc", bus.if_id_pc, 32'h0);
        check("rst_if_id_instr", bus.if_id_instr, 32'h0);
        check("rst_if_id_pc_plus4", bus.if_id_pc_plus4, 32'h0);
        for (int i = 0; i < 8; i++) exp_push(32'(i * 4), 32'(i * 4 + 4));
        @(negedge clk);
        #3;
        check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("first_req_addr", bus.imem_req_addr, 32'h0);
        drain("t1_drain");
`ifdef FETCH_PERF_CNT_EN
        #3;
        check("perf_fetched_8", perf_fetched, 32'd8);
`endif

        // 2: ID stalled for 5 cycles, credits cap outstanding fetches
        do_reset();
        exp_push(32'h00, 32'h04); exp_push(32'h04, 32'h08); exp_push(32'h08, 32'h0C);
        exp_push(32'h0C, 32'h10); exp_push(32'h10, 32'h14); exp_push(32'h14, 32'h18);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #3;
            check("stall_valid", 32'(bus.if_id_valid), 32'd1);
            check("stall_pc", bus.if_id_pc, 32'h0);
            check("stall_instr", bus.if_id_instr, 32'hA5A5_0000);
            @(negedge clk);
        end
        #3;
        check("stall_fetches", 32'(fire_count), 32'd2);
        @(negedge clk);
        bus.if_id_ready = 1'b1;
        drain("t2_drain");

        // 3: redirect to 0x103 while the response for 0x8 arrives
        do_reset();
        bus.if_id_ready = 1'b1;
        exp_push(32'h000, 32'h004); exp_push(32'h004, 32'h008);
        exp_push(32'h100, 32'h104); exp_push(32'h104, 32'h108);
        exp_push(32'h108, 32'h10C); exp_push(32'h10C, 32'h110);
        repeat (5) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        #3;
        check("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #3;
        check("redir_if_id_valid", 32'(bus.if_id_valid), 32'd0);
        check("redir_req_addr", bus.imem_req_addr, 32'h100);
        drain("t3_drain");

        // 3b: redirect over a presented word, then back-to-back redirects
        do_reset();
        bus.if_id_ready = 1'b1;
        exp_push(32'h80, 32'h84); exp_push(32'h84, 32'h88);
        exp_push(32'h88, 32'h8C); exp_push(32'h8C, 32'h90);
        repeat (3) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #3;
        check("b2b_head_pc", bus.if_id_pc, 32'h0);
        @(negedge clk);
        bus.redirect_pc = 32'h80;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #3;
        check("b2b_req_addr", bus.imem_req_addr, 32'h80);
        drain("t3b_drain");

        // 4: memory ready pattern 1,0,0,1 holds the stalled address
        do_reset();
        bus.if_id_ready = 1'b1;
        for (int i = 0; i < 6; i++) exp_push(32'(i * 4), 32'(i * 4 + 4));
        @(negedge clk);
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        #3;
        check("hold_addr_a", bus.imem_req_addr, 32'h4);
        @(negedge clk);
        #3;
        check("hold_addr_b", bus.imem_req_addr, 32'h4);
        check("hold_valid", 32'(bus.imem_req_valid), 32'd1);
        @(negedge clk);
        bus.imem_req_ready = 1'b1;
        #3;
        check("hold_addr_c", bus.imem_req_addr, 32'h4);
        drain("t4_drain");

        // 5: fetch PC wraps from 0xFFFF_FFFC to 0x0
        do_reset();
        bus.if_id_ready = 1'b1;
        exp_push(32'hFFFF_FFFC, 32'h0); exp_push(32'h0, 32'h4);
        exp_push(32'h4, 32'h8);         exp_push(32'h8, 32'hC);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #3;
        check("wrap_addr_a", bus.imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        #3;
        check("wrap_addr_b", bus.imem_req_addr, 32'h0);
        drain("t5_drain");

        // 6: reset while stalled with a full queue
        do_reset();
        repeat (6) @(negedge clk);
        #3;
        check("full_valid", 32'(bus.if_id_valid), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check("perf_stall_3", perf_stall, 32'd3);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("rerst_if_id_valid", 32'(bus.if_id_valid), 32'd0);
        check("rerst_req_valid", 32'(bus.imem_req_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rerst_perf_fetched", perf_fetched, 32'd0);
        check("rerst_perf_stall", perf_stall, 32'd0);
`endif
        exp_push(32'h0, 32'h4); exp_push(32'h4, 32'h8); exp_push(32'h8, 32'hC);
        @(negedge clk);
        bus.if_id_ready = 1'b1;
        #3;
        check("rerst_req_addr", bus.imem_req_addr, 32'h0);
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
